// File: rtl/sync_pkg.sv
// Shared constants and helpers for the synchroniser family.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
//
// Contents: default chain depth and filter length used by all synchroniser
// users, plus the counter-width helper for the stability filter.
package sync_pkg;

    localparam int unsigned SYNC_DEPTH_DEFAULT  = 3;
    localparam int unsigned SYNC_FILTER_DEFAULT = 4;

    // Width of a counter that must hold values 0..filter.
    function automatic int unsigned cnt_width(input int unsigned filter);
        return $clog2(filter + 1);
    endfunction

endpackage

// File: rtl/sync_filter_ch.sv
// One channel: DEPTH-flop synchroniser, stability filter, level and edge pulses.
// Latency: DEPTH+FILTER-1 cycles from the sampling edge (DEPTH without SYNC_FILTER_EN).
// Backpressure: none; free-running, the output level simply follows the input.
//
// Ports:
//   clock    destination clock, all state on its rising edge
//   rst      asynchronous active-high reset
//   sig_in   asynchronous input bit
//   sig_out  filtered, synchronised level
//   rise     one-cycle pulse on sig_out 0->1
//   fall     one-cycle pulse on sig_out 1->0
//   change   one-cycle pulse on any sig_out transition
// Build option: SYNC_FILTER_EN enables the stability counter; without it the
// channel behaves as FILTER=1.
module sync_filter_ch
    import sync_pkg::*;
#(
    parameter int unsigned DEPTH     = SYNC_DEPTH_DEFAULT,
    parameter int unsigned FILTER    = SYNC_FILTER_DEFAULT,
    parameter logic        RESET_VAL = 1'b0
) (
    input  logic clock,
    input  logic rst,
    input  logic sig_in,
    output logic sig_out,
    output logic rise,
    output logic fall,
    output logic change
);

    // Elaboration-time parameter sanity.
    if (DEPTH < 2) begin : g_bad_depth
        $error("sync_filter_ch: DEPTH must be at least 2");
    end
    if (FILTER < 1) begin : g_bad_filter
        $error("sync_filter_ch: FILTER must be at least 1");
    end

    // Synchroniser chain. These flops must stay a plain shift chain so the
    // metastability resolution time is not eaten by merging or retiming.
    (* preserve *) logic [DEPTH-1:0] chain_q;
    logic [DEPTH-1:0] chain_d;
    logic             s;

    logic sig_out_q, sig_out_d;
    logic rise_q,    rise_d;
    logic fall_q,    fall_d;
    logic change_q,  change_d;

    always_comb begin
        chain_d = {chain_q[DEPTH-2:0], sig_in};
    end

    assign s = chain_q[DEPTH-1];

`ifdef SYNC_FILTER_EN
    localparam int unsigned    CW       = cnt_width(FILTER);
    localparam logic [CW-1:0] CNT_LAST = CW'(FILTER - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    // The level only moves once s has disagreed with it for FILTER
    // consecutive cycles; any agreement in between restarts the count.
    always_comb begin
        cnt_d     = cnt_q;
        sig_out_d = sig_out_q;
        rise_d    = 1'b0;
        fall_d    = 1'b0;
        change_d  = 1'b0;
        if (s == sig_out_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            cnt_d     = '0;
            sig_out_d = s;
            rise_d    = s;
            fall_d    = ~s;
            change_d  = 1'b1;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    // Unfiltered: the level tracks s every cycle, pulses from the compare.
    always_comb begin
        sig_out_d = s;
        rise_d    = s & ~sig_out_q;
        fall_d    = ~s & sig_out_q;
        change_d  = s ^ sig_out_q;
    end
`endif

    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            chain_q   <= {DEPTH{RESET_VAL}};
            sig_out_q <= RESET_VAL;
            rise_q    <= 1'b0;
            fall_q    <= 1'b0;
            change_q  <= 1'b0;
        end else begin
            chain_q   <= chain_d;
            sig_out_q <= sig_out_d;
            rise_q    <= rise_d;
            fall_q    <= fall_d;
            change_q  <= change_d;
        end
    end

    assign sig_out = sig_out_q;
    assign rise    = rise_q;
    assign fall    = fall_q;
    assign change  = change_q;

endmodule

// File: rtl/sync_bus_filter.sv
// Multi-channel synchroniser with per-channel glitch filter and edge detection.
// Latency: DEPTH+FILTER-1 cycles from the sampling edge (DEPTH without SYNC_FILTER_EN).
// Backpressure: none; every channel is free-running and independent.
//
// Ports:
//   clock    destination clock
//   rst      asynchronous active-high reset
//   sig_in   [WIDTH] asynchronous inputs
//   sig_out  [WIDTH] filtered, synchronised levels
//   rise     [WIDTH] one-cycle pulses on 0->1
//   fall     [WIDTH] one-cycle pulses on 1->0
//   change   [WIDTH] one-cycle pulses on any transition
// Build option: SYNC_FILTER_EN enables the stability filter.
module sync_bus_filter
    import sync_pkg::*;
#(
    parameter int unsigned      WIDTH     = 4,
    parameter int unsigned      DEPTH     = SYNC_DEPTH_DEFAULT,
    parameter int unsigned      FILTER    = SYNC_FILTER_DEFAULT,
    parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}}
) (
    input  logic             clock,
    input  logic             rst,
    input  logic [WIDTH-1:0] sig_in,
    output logic [WIDTH-1:0] sig_out,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall,
    output logic [WIDTH-1:0] change
);

    if (WIDTH < 1) begin : g_bad_width
        $error("sync_bus_filter: WIDTH must be at least 1");
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_ch
        sync_filter_ch #(
            .DEPTH     (DEPTH),
            .FILTER    (FILTER),
            .RESET_VAL (RESET_VAL[i])
        ) u_ch (
            .clock   (clock),
            .rst     (rst),
            .sig_in  (sig_in[i]),
            .sig_out (sig_out[i]),
            .rise    (rise[i]),
            .fall    (fall[i]),
            .change  (change[i])
        );
    end

endmodule

// File: tb/tb_sync_bus_filter.sv
// Directed bench for sync_bus_filter: reset, step latency, glitch rejection,
// channel independence and mid-count reset, for either build option.
module tb_sync_bus_filter;

    localparam int unsigned DEPTH  = 3;
    localparam int unsigned FILTER = 4;
`ifdef SYNC_FILTER_EN
    localparam int EFF = FILTER;
`else
    localparam int EFF = 1;
`endif
    // Edge index (relative to the sampling edge of a change) at which
    // sig_out and the pulses are first visible.
    localparam int L = DEPTH + EFF - 1;

    logic       clock = 1'b0;
    logic       rst   = 1'b1;
    logic [3:0] sig_in = 4'b0000;
    logic [3:0] sig_out, rise, fall, change;

    int n_tests = 0;
    int n_fail  = 0;

    sync_bus_filter #(
        .WIDTH     (4),
        .DEPTH     (DEPTH),
        .FILTER    (FILTER),
        .RESET_VAL (4'b0101)
    ) dut (
        .clock   (clock),
        .rst     (rst),
        .sig_in  (sig_in),
        .sig_out (sig_out),
        .rise    (rise),
        .fall    (fall),
        .change  (change)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", tag, got, exp);
        end
    endtask

    // Advance to 1 time unit after the next rising edge.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Drive v1 now (sampled at the next edge, j=1); after step t2 switch the
    // input to v2. Pulses expected exactly at step rise_at / fall_at
    // (0 = never), level tracked from lvl0.
    task automatic run(input string tag, input int n,
                       input logic [3:0] v1, input int t2, input logic [3:0] v2,
                       input int rise_at, input logic [3:0] rmask,
                       input int fall_at, input logic [3:0] fmask,
                       input logic [3:0] lvl0);
        logic [3:0] lvl, er, ef;
        lvl    = lvl0;
        sig_in = v1;
        for (int j = 1; j <= n; j++) begin
            step();
            er = (j == rise_at) ? rmask : 4'b0000;
            ef = (j == fall_at) ? fmask : 4'b0000;
            lvl = (lvl | er) & ~ef;
            check($sformatf("%s.lvl@%0d", tag, j), sig_out, lvl);
            check($sformatf("%s.rise@%0d", tag, j), rise, er);
            check($sformatf("%s.fall@%0d", tag, j), fall, ef);
            check($sformatf("%s.chg@%0d", tag, j), change, er | ef);
            if (j == t2) sig_in = v2;
        end
    endtask

    initial begin
        // Reset held: outputs at RESET_VAL, no pulses.
        step();
        step();
        check("rst.lvl", sig_out, 4'b0101);
        check("rst.rise", rise, 4'b0000);
        check("rst.fall", fall, 4'b0000);
        check("rst.chg", change, 4'b0000);

        // Release with inputs 0: fall on ch0/ch2 only, L edges after sampling.
        rst = 1'b0;
        run("rst_rel", L + 3, 4'b0000, 0, 4'b0000, 0, 4'b0000, L + 1, 4'b0101, 4'b0101);

        // Single-channel step up, then back down.
        run("step_up", L + 3, 4'b0010, 0, 4'b0010, L + 1, 4'b0010, 0, 4'b0000, 4'b0000);
        run("step_dn", L + 3, 4'b0000, 0, 4'b0000, 0, 4'b0000, L + 1, 4'b0010, 4'b0010);

`ifdef SYNC_FILTER_EN
        // Pulse shorter than FILTER is swallowed; a 5-cycle pulse passes.
        run("glitch3", L + 4, 4'b0100, 3, 4'b0000, 0, 4'b0000, 0, 4'b0000, 4'b0000);
        run("pulse5", L + 8, 4'b0100, 5, 4'b0000, L + 1, 4'b0100, L + 6, 4'b0100, 4'b0000);
`else
        // Unfiltered: a one-cycle glitch shows up as rise then fall.
        run("glitch1", L + 4, 4'b0100, 1, 4'b0000, L + 1, 4'b0100, L + 2, 4'b0100, 4'b0000);
`endif

        // All channels switch on the same edge.
        run("all_up", L + 3, 4'b1111, 0, 4'b1111, L + 1, 4'b1111, 0, 4'b0000, 4'b0000);
        run("all_dn", L + 3, 4'b0000, 0, 4'b0000, 0, 4'b0000, L + 1, 4'b1111, 4'b1111);

        // Start a transition on ch1, reset before it completes.
        run("pend", L - 1, 4'b0010, 0, 4'b0010, 0, 4'b0000, 0, 4'b0000, 4'b0000);
        rst = 1'b1;
        #1;
        check("mid_rst.lvl", sig_out, 4'b0101);
        check("mid_rst.rise", rise, 4'b0000);
        check("mid_rst.fall", fall, 4'b0000);
        check("mid_rst.chg", change, 4'b0000);
        sig_in = 4'b0101;
        step();
        step();
        rst = 1'b0;
        // Inputs equal RESET_VAL: nothing may fire after release.
        run("post_rst", L + 4, 4'b0101, 0, 4'b0101, 0, 4'b0000, 0, 4'b0000, 4'b0101);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
